// File: rtl/mem_access_unit.sv
// Memory access unit: accepts one load/store/fetch request, runs a single
// handshaked memory cycle with timeout, and returns aligned, extended load data.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a request; request fields latched on acceptance
// BUSY  | mem_req held with stable address/strobe/data until ack or timeout
// RESP  | one-cycle rsp_valid pulse carrying rdata and err
module mem_access_unit #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        err,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic        r_write;
  logic [31:0] r_addr;
  logic [2:0]  r_funct3;
  logic [31:0] r_wdata;
  logic        r_err;
  logic [31:0] r_rdata;

  logic        w_idle;
  logic        w_busy;
  logic        w_resp;
  logic        w_accept;
  logic        w_fault;
  logic        w_cnt_tc;
  logic [31:0] w_shifted;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [3:0]  w_strb;
  logic [31:0] w_wdata;

  assign w_idle   = (r_state == S_IDLE);
  assign w_busy   = (r_state == S_BUSY);
  assign w_resp   = (r_state == S_RESP);
  assign w_accept = req_valid & w_idle;
  assign w_cnt_tc = (r_cnt == '0);

  // Fault classification is done on the live request so a faulting access
  // never raises mem_req.
  always_comb begin
    w_fault = 1'b0;
    case (req_funct3)
      3'b000, 3'b100: w_fault = 1'b0;
      3'b001, 3'b101: w_fault = req_addr[0];
      3'b010:         w_fault = (req_addr[1:0] != 2'b00);
      default:        w_fault = 1'b1;
    endcase
    if (req_write && req_funct3[2]) begin
      w_fault = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_fault ? S_RESP : S_BUSY;
        end
      end
      S_BUSY: begin
        if (mem_ack || w_cnt_tc) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_shifted = mem_rdata >> {r_addr[1:0], 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    w_load_data = 32'h0;
    if (!r_write) begin
      case (r_funct3)
        3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
        3'b100:  w_load_data = {24'h0, w_byte};
        3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
        3'b101:  w_load_data = {16'h0, w_half};
        3'b010:  w_load_data = mem_rdata;
        default: w_load_data = 32'h0;
      endcase
    end
  end

  always_comb begin
    w_strb  = 4'b0000;
    w_wdata = 32'h0;
    if (r_write) begin
      case (r_funct3[1:0])
        2'b00: begin
          w_strb  = 4'b0001 << r_addr[1:0];
          w_wdata = {4{r_wdata[7:0]}};
        end
        2'b01: begin
          w_strb  = 4'b0011 << r_addr[1:0];
          w_wdata = {2{r_wdata[15:0]}};
        end
        default: begin
          w_strb  = 4'b1111;
          w_wdata = r_wdata;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_write  <= 1'b0;
      r_addr   <= 32'h0;
      r_funct3 <= 3'b000;
      r_wdata  <= 32'h0;
      r_err    <= 1'b0;
      r_rdata  <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_write  <= req_write;
        r_addr   <= req_addr;
        r_funct3 <= req_funct3;
        r_wdata  <= req_wdata;
        r_err    <= w_fault;
        r_rdata  <= 32'h0;
        r_cnt    <= CW'(TIMEOUT_CYC - 1);
      end else if (w_busy) begin
        // Ack wins over timeout when both land in the final BUSY cycle.
        if (mem_ack) begin
          r_rdata <= w_load_data;
        end else if (w_cnt_tc) begin
          r_err <= 1'b1;
        end else begin
          r_cnt <= r_cnt - CW'(1);
        end
      end
    end
  end

  // Memory-side outputs are gated by state so an async reset drops them at once.
  assign req_ready = w_idle;
  assign stall     = ~w_idle;
  assign rsp_valid = w_resp;
  assign rsp_rdata = w_resp ? r_rdata : 32'h0;
  assign err       = w_resp & r_err;
  assign mem_req   = w_busy;
  assign mem_we    = w_busy & r_write;
  assign mem_addr  = w_busy ? {r_addr[31:2], 2'b00} : 32'h0;
  assign mem_wstrb = w_busy ? w_strb : 4'b0000;
  assign mem_wdata = w_busy ? w_wdata : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed requests push expected
// responses; an independent monitor pops and compares on every rsp_valid.
module tb_mem_access_unit;

  localparam int TIMEOUT = 16;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        err;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  mem_access_unit #(.TIMEOUT_CYC(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_funct3 (req_funct3),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .err        (err),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every response against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        if (q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 expected none (cycle %0d)", cyc);
        end else begin
          e = q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", {31'h0, err}, {31'h0, e.err});
          chk("rsp_cycle", 32'(cyc), 32'(e.due));
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (req_ready !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk("wait_idle_timeout", 32'(n), 32'd0);
  endtask

  // d: cycles of BUSY before ack (-1 = never ack).
  task automatic run_req(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [2:0] f3, input logic [31:0] wd, input bit fault,
                         input int d, input logic [31:0] rd, input logic [31:0] exp_rd,
                         input logic [31:0] exp_maddr, input logic [3:0] exp_strb,
                         input logic [31:0] exp_wd);
    exp_t e;
    int   a;
    int   lat;
    int   cnt;
    wait_idle();
    req_valid  = 1'b1;
    req_write  = wr;
    req_addr   = addr;
    req_funct3 = f3;
    req_wdata  = wd;
    a = cyc;
    lat = fault ? 1 : ((d < 0) ? 1 + TIMEOUT : 2 + d);
    e.rdata = exp_rd;
    e.err   = fault || (d < 0);
    e.due   = a + lat;
    q.push_back(e);
    @(negedge clk);
    req_valid  = 1'b0;
    req_write  = ~wr;
    req_addr   = ~addr;
    req_funct3 = 3'b111;
    req_wdata  = ~wd;
    chk({tag, "_stall"}, {31'h0, stall}, 32'd1);
    chk({tag, "_ready_low"}, {31'h0, req_ready}, 32'd0);
    if (fault) begin
      chk({tag, "_no_mem_req"}, {31'h0, mem_req}, 32'd0);
    end else begin
      chk({tag, "_mem_req"}, {31'h0, mem_req}, 32'd1);
      chk({tag, "_mem_we"}, {31'h0, mem_we}, {31'h0, wr});
      chk({tag, "_mem_addr"}, mem_addr, exp_maddr);
      chk({tag, "_mem_wstrb"}, {28'h0, mem_wstrb}, {28'h0, exp_strb});
      if (wr) chk({tag, "_mem_wdata"}, mem_wdata, exp_wd);
      if (d >= 0) begin
        repeat (d) @(negedge clk);
        if (d > 0) chk({tag, "_mem_addr_hold"}, mem_addr, exp_maddr);
        mem_ack   = 1'b1;
        mem_rdata = rd;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 32'h5A5A_A5A5;
      end else begin
        cnt = 0;
        while (mem_req === 1'b1 && cnt < 40) begin
          cnt++;
          @(negedge clk);
        end
        chk({tag, "_mem_req_cycles"}, 32'(cnt), 32'(TIMEOUT));
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        mem_ack   = 1'b0;
      end
    end
    wait_idle();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 32'h0;
    req_funct3 = 3'b000;
    req_wdata  = 32'h0;
    mem_ack    = 1'b0;
    mem_rdata  = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", {31'h0, mem_req}, 32'd0);
    chk("rst_stall", {31'h0, stall}, 32'd0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'h0, req_ready}, 32'd1);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_err", {31'h0, err}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_bus", {27'h0, mem_we, mem_wstrb}, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);

    //       tag    wr    addr          f3      wdata         flt  d   mem_rdata     exp_rdata     mem_addr      strb     mem_wdata
    run_req("lw",   1'b0, 32'h0000_0100, 3'b010, 32'h0,        0,  0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0100, 4'b0000, 32'h0);
    run_req("lb",   1'b0, 32'h0000_0103, 3'b000, 32'h0,        0,  1, 32'h80FF_0000, 32'hFFFF_FF80, 32'h0000_0100, 4'b0000, 32'h0);
    run_req("lbu",  1'b0, 32'h0000_0103, 3'b100, 32'h0,        0,  0, 32'h80FF_0000, 32'h0000_0080, 32'h0000_0100, 4'b0000, 32'h0);
    run_req("sh",   1'b1, 32'h0000_0202, 3'b001, 32'h1234_ABCD, 0, 2, 32'h0,        32'h0,        32'h0000_0200, 4'b1100, 32'hABCD_ABCD);
    run_req("lh",   1'b0, 32'h0000_0102, 3'b001, 32'h0,        0,  0, 32'h8001_1234, 32'hFFFF_8001, 32'h0000_0100, 4'b0000, 32'h0);
    run_req("lhu",  1'b0, 32'h0000_0100, 3'b101, 32'h0,        0,  0, 32'h8001_9234, 32'h0000_9234, 32'h0000_0100, 4'b0000, 32'h0);
    run_req("lb1",  1'b0, 32'h0000_0101, 3'b000, 32'h0,        0,  0, 32'h0000_7F00, 32'h0000_007F, 32'h0000_0100, 4'b0000, 32'h0);
    run_req("sb",   1'b1, 32'h0000_0301, 3'b000, 32'hAAAA_AA55, 0, 3, 32'h0,        32'h0,        32'h0000_0300, 4'b0010, 32'h5555_5555);
    run_req("sw",   1'b1, 32'h0000_0400, 3'b010, 32'hCAFE_F00D, 0, 0, 32'h0,        32'h0,        32'h0000_0400, 4'b1111, 32'hCAFE_F00D);
    run_req("lw_mis", 1'b0, 32'h0000_0101, 3'b010, 32'h0,      1,  0, 32'h0,        32'h0,        32'h0,        4'b0000, 32'h0);
    run_req("lh_mis", 1'b0, 32'h0000_0103, 3'b001, 32'h0,      1,  0, 32'h0,        32'h0,        32'h0,        4'b0000, 32'h0);
    run_req("f3_011", 1'b0, 32'h0000_0100, 3'b011, 32'h0,      1,  0, 32'h0,        32'h0,        32'h0,        4'b0000, 32'h0);
    run_req("sbu",  1'b1, 32'h0000_0100, 3'b100, 32'h0000_0011, 1, 0, 32'h0,        32'h0,        32'h0,        4'b0000, 32'h0);
    run_req("tmo",  1'b0, 32'h0000_0500, 3'b010, 32'h0,        0, -1, 32'h0,        32'h0,        32'h0000_0500, 4'b0000, 32'h0);
    run_req("lw2",  1'b0, 32'h0000_0104, 3'b010, 32'h0,        0,  0, 32'h1357_9BDF, 32'h1357_9BDF, 32'h0000_0104, 4'b0000, 32'h0);

    // Reset in the middle of a BUSY access: outputs drop at once, no response.
    wait_idle();
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_addr   = 32'h0000_0600;
    req_funct3 = 3'b010;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstb_mem_req_before", {31'h0, mem_req}, 32'd1);
    reset = 1'b0;
    #1;
    chk("rstb_mem_req", {31'h0, mem_req}, 32'd0);
    chk("rstb_stall", {31'h0, stall}, 32'd0);
    chk("rstb_mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    reset     = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'h1111_2222;
    @(negedge clk);
    mem_ack = 1'b0;
    repeat (4) @(negedge clk);
    chk("rstb_ready", {31'h0, req_ready}, 32'd1);

    run_req("post", 1'b0, 32'h0000_0102, 3'b101, 32'h0,        0,  0, 32'hBEEF_0000, 32'h0000_BEEF, 32'h0000_0100, 4'b0000, 32'h0);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYC, 16, max BUSY cycles waiting for mem_ack before fault.
REQ-002 SHALL have port: clk  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port: req_valid  in  1  controller requests access (fetch/load/store).
REQ-005 SHALL have port: req_write  in  1  1 = store, 0 = load/fetch.
REQ-006 SHALL have port: req_addr  in  32  byte address (PC or ALU result).
REQ-007 SHALL have port: req_funct3  in  3  size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-008 SHALL have port: req_wdata  in  32  store data, right-aligned.
REQ-009 SHALL have port: req_ready  out  1  unit idle, request accepted when req_valid & req_ready.
REQ-010 SHALL have port: rsp_valid  out  1  one-cycle completion pulse.
REQ-011 SHALL have port: rsp_rdata  out  32  aligned, extended load data.
REQ-012 SHALL have port: err  out  1  fault flag, valid only with rsp_valid.
REQ-013 SHALL have port: stall  out  1  access in progress; controller holds state.
REQ-014 SHALL have ports: mem_req out 1, mem_we out 1, mem_addr out 32 (word-aligned), mem_wstrb out 4, mem_wdata out 32, mem_ack in 1, mem_rdata in 32.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-016 SHALL, in IDLE, drive req_ready=1; acceptance latches write, addr, funct3, wdata; later input changes SHALL NOT affect the access.
REQ-017 SHALL detect on acceptance: illegal funct3 (011,110,111; store with funct3[2]=1), misalignment (h with addr[0]=1, w with addr[1:0]!=0); fault -> RESP with err=1, no memory cycle.
REQ-018 SHALL otherwise go IDLE->BUSY; in BUSY drive mem_req=1 and hold mem_we, mem_addr={addr[31:2],2'b00}, mem_wstrb, mem_wdata stable until mem_ack.
REQ-019 SHALL set strobes: b 0001<<addr[1:0]; h 0011<<addr[1:0]; w 1111; loads 0000.
REQ-020 SHALL set mem_wdata: b byte replicated x4; h halfword replicated x2; w unchanged.
REQ-021 SHALL, on mem_ack in BUSY, capture mem_rdata and go to RESP next edge.
REQ-022 SHALL count BUSY cycles; on reaching TIMEOUT_CYC without mem_ack, drop mem_req, go RESP with err=1.
REQ-023 SHALL, in RESP, pulse rsp_valid=1 for exactly one cycle, then return to IDLE.
REQ-024 SHALL produce rsp_rdata for loads: select byte/half at addr[1:0]/addr[1]; sign-extend for 000/001, zero-extend for 100/101; word unchanged; stores and faults give 0.
REQ-025 SHALL drive stall=1 whenever state != IDLE, including the cycle of acceptance's next edge through RESP.
REQ-026 SHALL have minimum latency 2 cycles acceptance->rsp_valid (ack in first BUSY cycle); fault latency 1 cycle.
REQ-027 SHALL ignore mem_ack outside BUSY (spurious or late ack).
REQ-028 SHALL NOT accept a new request until back in IDLE; back-to-back requests separated by one idle-cycle minimum.

Reset
REQ-029 SHALL, on reset low, asynchronously force IDLE, clear timeout counter and latched request.
REQ-030 SHALL reset outputs: req_ready=1 (while reset deasserted), rsp_valid=0, rsp_rdata=0, err=0, stall=0, mem_req=0, mem_we=0, mem_addr=0, mem_wstrb=0, mem_wdata=0.
REQ-031 SHALL, on reset mid-BUSY, drop mem_req immediately and emit no rsp_valid for the aborted access.

Verification
REQ-032 SHALL pass: lw addr 0x100, ack next cycle with 0xDEADBEEF -> rsp_valid 2 cycles after accept, rsp_rdata=0xDEADBEEF, err=0.
REQ-033 SHALL pass: lb addr 0x103, mem_rdata 0x80FF_0000 -> rsp_rdata=0xFFFFFF80; lbu same -> 0x00000080.
REQ-034 SHALL pass: sh addr 0x202 data 0x1234ABCD -> mem_addr=0x200, mem_wstrb=1100, mem_wdata=0xABCDABCD, mem_we=1.
REQ-035 SHALL pass: lw addr 0x101 -> no mem_req, rsp_valid next cycle with err=1, rsp_rdata=0.
REQ-036 SHALL pass: lw with mem_ack never asserted -> mem_req high 16 cycles, then rsp_valid with err=1; later mem_ack ignored.
REQ-037 SHALL pass: reset low during BUSY -> mem_req=0 and stall=0 same cycle, no rsp_valid after release.
